// File: rtl/line_tracker_pkg.sv
// Shared definitions for the line tracker front end.
// Holds the motor-stage mode codes, the lost-line FSM state encoding and a
// helper that classifies a committed pattern as a left or right turn.
package line_tracker_pkg;

  // {left, centre, right} command words understood by the motor stage.
  localparam logic [2:0] MODE_FWD    = 3'b111;
  localparam logic [2:0] MODE_NONE   = 3'b000;
  localparam logic [2:0] MODE_REV    = 3'b010;
  localparam logic [2:0] MODE_HARD_L = 3'b100;
  localparam logic [2:0] MODE_HARD_R = 3'b001;

  // Encoding is visible on the debug state port, so values are fixed.
  typedef enum logic [1:0] {
    StTrack = 2'd0,
    StHold  = 2'd1,
    StLost  = 2'd2
  } track_state_e;

  // Returns {is_turn, side}. is_turn is set when exactly one of the outer
  // sensors sees the line; side is 0 for left (100/110), 1 for right (001/011).
  function automatic logic [1:0] turn_side(input logic [2:0] pat);
    turn_side = {pat[2] ^ pat[0], pat[0]};
  endfunction

endpackage

// File: rtl/tracker_debounce.sv
// Input conditioning for the line tracker.
// Synchronises the three raw IR sensors, divides clk down to a sample tick
// and debounces the joint 3-bit pattern on that tick.
//
// Ports:
//   clk, rst            - system clock, asynchronous active-low reset
//   sensor_l/c/r        - raw asynchronous sensor inputs
//   tick                - one-cycle pulse at the sample rate
//   commit              - pattern has been stable for DEBOUNCE_N ticks (tick only)
//   commit_pat          - pattern being committed, valid while commit is high
module tracker_debounce
  import line_tracker_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV         = 100000,
  parameter int unsigned DEBOUNCE_N         = 4,
  parameter int unsigned SENSOR_ACTIVE_HIGH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_l,
  input  logic       sensor_c,
  input  logic       sensor_r,
  output logic       tick,
  output logic       commit,
  output logic [2:0] commit_pat
);

  localparam int unsigned DivW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(SAMPLE_DIV - 1);
  localparam logic [3:0] StableMax = 4'(DEBOUNCE_N - 1);

  logic [2:0]      sync1_q, sync2_q;
  logic [2:0]      sync_pat;
  logic [DivW-1:0] div_q, div_d;
  logic [2:0]      cand_q, cand_d;
  logic [3:0]      stable_q, stable_d;

  // Two-flop synchroniser per sensor.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
    end else begin
      sync1_q <= {sensor_l, sensor_c, sensor_r};
      sync2_q <= sync1_q;
    end
  end

  assign sync_pat = (SENSOR_ACTIVE_HIGH != 0) ? sync2_q : ~sync2_q;

  // Free-running divider; tick marks the cycle whose edge wraps it to 0.
  assign tick  = (div_q == DivMax);
  assign div_d = tick ? '0 : div_q + 1'b1;

  always_comb begin
    cand_d   = cand_q;
    stable_d = stable_q;
    if (tick) begin
      if (sync_pat == cand_q) begin
        if (stable_q != StableMax) begin
          stable_d = stable_q + 4'd1;
        end
      end else begin
        cand_d   = sync_pat;
        stable_d = 4'd0;
      end
    end
  end

  // Once saturated every tick re-commits, which keeps the lost timer running.
  assign commit     = tick && (stable_d == StableMax);
  assign commit_pat = cand_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q    <= '0;
      cand_q   <= MODE_FWD;
      stable_q <= 4'd0;
    end else begin
      div_q    <= div_d;
      cand_q   <= cand_d;
      stable_q <= stable_d;
    end
  end

endmodule

// File: rtl/line_tracker_frontend.sv
// Line tracker front end: sensor conditioning plus the lost-line FSM that
// drives the registered mode word consumed by the motor stage.
//
// Optional feature: define LINE_TRACKER_LAST_TURN_EN to remember the side of
// the last one-sided pattern and steer hard left/right while lost instead of
// reversing.
//
// Ports:
//   clk, rst            - system clock, asynchronous active-low reset
//   sensor_l/c/r        - raw asynchronous IR sensors
//   mode[2:0]           - {left, centre, right} command word (registered)
//   mode_chg            - one-cycle pulse in the cycle mode takes a new value
//   lost                - high while the FSM is in LOST
//   state[1:0]          - FSM state for debug (TRACK=0, HOLD=1, LOST=2)
module line_tracker_frontend
  import line_tracker_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV         = 100000,
  parameter int unsigned DEBOUNCE_N         = 4,
  parameter int unsigned LOST_TICKS         = 200,
  parameter int unsigned SENSOR_ACTIVE_HIGH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_l,
  input  logic       sensor_c,
  input  logic       sensor_r,
  output logic [2:0] mode,
  output logic       mode_chg,
  output logic       lost,
  output logic [1:0] state
);

  localparam int unsigned LostW = $clog2(LOST_TICKS + 1);
  localparam logic [LostW-1:0] LostMax = LostW'(LOST_TICKS);

  logic             tick;
  logic             commit;
  logic [2:0]       commit_pat;
  logic             nz_commit;
  logic [2:0]       lost_mode;

  track_state_e     state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic             mode_chg_q, mode_chg_d;
  logic [LostW-1:0] lost_cnt_q, lost_cnt_d;

  tracker_debounce #(
    .SAMPLE_DIV         (SAMPLE_DIV),
    .DEBOUNCE_N         (DEBOUNCE_N),
    .SENSOR_ACTIVE_HIGH (SENSOR_ACTIVE_HIGH)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .sensor_l   (sensor_l),
    .sensor_c   (sensor_c),
    .sensor_r   (sensor_r),
    .tick       (tick),
    .commit     (commit),
    .commit_pat (commit_pat)
  );

  assign nz_commit = commit && (commit_pat != MODE_NONE);

`ifdef LINE_TRACKER_LAST_TURN_EN
  logic       last_turn_q, last_turn_d;  // 0 = left, 1 = right
  logic [1:0] side;

  always_comb begin
    last_turn_d = last_turn_q;
    side        = turn_side(commit_pat);
    if (commit && side[1]) begin
      last_turn_d = side[0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_turn_q <= 1'b0;
    end else begin
      last_turn_q <= last_turn_d;
    end
  end

  assign lost_mode = last_turn_q ? MODE_HARD_R : MODE_HARD_L;
`else
  assign lost_mode = MODE_REV;
`endif

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    lost_cnt_d = lost_cnt_q;
    case (state_q)
      StTrack: begin
        if (commit) begin
          if (commit_pat == MODE_NONE) begin
            state_d    = StHold;
            lost_cnt_d = '0;
            mode_d     = MODE_NONE;
          end else begin
            mode_d = commit_pat;
          end
        end
      end
      StHold: begin
        // A nonzero commit wins over the lost terminal count on the same tick.
        if (nz_commit) begin
          state_d = StTrack;
          mode_d  = commit_pat;
        end else if (tick) begin
          if (lost_cnt_q != LostMax) begin
            lost_cnt_d = lost_cnt_q + 1'b1;
          end
          if (lost_cnt_d == LostMax) begin
            state_d = StLost;
            mode_d  = lost_mode;
          end
        end
      end
      StLost: begin
        if (nz_commit) begin
          state_d = StTrack;
          mode_d  = commit_pat;
        end else begin
          mode_d = lost_mode;
        end
      end
      default: begin
        state_d = StTrack;
        mode_d  = MODE_FWD;
      end
    endcase
    mode_chg_d = (mode_d != mode_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StTrack;
      mode_q     <= MODE_FWD;
      mode_chg_q <= 1'b0;
      lost_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      mode_chg_q <= mode_chg_d;
      lost_cnt_q <= lost_cnt_d;
    end
  end

  assign mode     = mode_q;
  assign mode_chg = mode_chg_q;
  assign lost     = (state_q == StLost);
  assign state    = state_q;

endmodule

// File: tb/tb_line_tracker_frontend.sv
// Directed bench for line_tracker_frontend with SAMPLE_DIV=4, DEBOUNCE_N=3,
// LOST_TICKS=5. Table vectors cover steady-state patterns; hand sequences
// cover latency, the lost timer and mid-operation reset.
module tb_line_tracker_frontend;

  logic       clk;
  logic       rst;
  logic       sensor_l, sensor_c, sensor_r;
  logic [2:0] mode;
  logic       mode_chg;
  logic       lost;
  logic [1:0] state;

  int total;
  int bad;
  int chg_cnt;

  line_tracker_frontend #(
    .SAMPLE_DIV         (4),
    .DEBOUNCE_N         (3),
    .LOST_TICKS         (5),
    .SENSOR_ACTIVE_HIGH (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sensor_l (sensor_l),
    .sensor_c (sensor_c),
    .sensor_r (sensor_r),
    .mode     (mode),
    .mode_chg (mode_chg),
    .lost     (lost),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sens;
    int         hold;
    logic [2:0] exp_mode;
    logic       exp_lost;
    logic [1:0] exp_state;
    int         exp_chg;
  } vec_t;

  vec_t vecs[7];

`ifdef LINE_TRACKER_LAST_TURN_EN
  localparam logic [2:0] LostMode = 3'b001;   // last one-sided commit was 011
  localparam logic [2:0] LostMode2 = 3'b100;  // last_turn reset to left
`else
  localparam logic [2:0] LostMode = 3'b010;
  localparam logic [2:0] LostMode2 = 3'b010;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (mode_chg) chg_cnt++;
    end
  endtask

  task automatic set_sens(input logic [2:0] p);
    {sensor_l, sensor_c, sensor_r} = p;
  endtask

  task automatic wait_state(input logic [1:0] s, input int bound, output int n);
    n = 0;
    while (state !== s && n < bound) begin
      step(1);
      n++;
    end
  endtask

  task automatic apply_vec(input int i);
    set_sens(vecs[i].sens);
    chg_cnt = 0;
    step(vecs[i].hold);
    chk($sformatf("v%0d_mode", i), 32'(mode), 32'(vecs[i].exp_mode));
    chk($sformatf("v%0d_lost", i), 32'(lost), 32'(vecs[i].exp_lost));
    chk($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
    chk($sformatf("v%0d_chg", i), 32'(chg_cnt), 32'(vecs[i].exp_chg));
  endtask

  initial begin
    int n;
    total   = 0;
    bad     = 0;
    chg_cnt = 0;

    vecs[0] = '{3'b111, 20, 3'b111, 1'b0, 2'd0, 0};
    vecs[1] = '{3'b111, 20, 3'b111, 1'b0, 2'd0, 1};  // back from 110
    vecs[2] = '{3'b011, 5,  3'b111, 1'b0, 2'd0, 0};  // short glitch
    vecs[3] = '{3'b111, 20, 3'b111, 1'b0, 2'd0, 0};
    vecs[4] = '{3'b011, 20, 3'b011, 1'b0, 2'd0, 1};
    vecs[5] = '{3'b011, 20, 3'b011, 1'b0, 2'd0, 1};  // recovery from LOST
    vecs[6] = '{3'b110, 20, 3'b110, 1'b0, 2'd0, 1};  // recovery after reset test

    // Reset state.
    rst = 1'b0;
    set_sens(3'b111);
    step(3);
    chk("rst_mode", 32'(mode), 32'h7);
    chk("rst_chg", 32'(mode_chg), 32'h0);
    chk("rst_lost", 32'(lost), 32'h0);
    chk("rst_state", 32'(state), 32'h0);
    rst = 1'b1;

    apply_vec(0);

    // 111 -> 110 must reach mode within 2 + 12 + 1 cycles with one pulse.
    chg_cnt = 0;
    set_sens(3'b110);
    n = 0;
    while (mode !== 3'b110 && n < 15) begin
      step(1);
      n++;
    end
    chk("lat_mode", 32'(mode), 32'h6);
    step(6);
    chk("lat_chg", 32'(chg_cnt), 32'h1);
    chk("lat_state", 32'(state), 32'h0);

    for (int i = 1; i <= 4; i++) apply_vec(i);

    // 000 held: HOLD, then LOST exactly five ticks (20 clk) later.
    chg_cnt = 0;
    set_sens(3'b000);
    wait_state(2'd1, 20, n);
    chk("hold_state", 32'(state), 32'h1);
    chk("hold_mode", 32'(mode), 32'h0);
    chk("hold_lost", 32'(lost), 32'h0);
    wait_state(2'd2, 40, n);
    chk("lost_state", 32'(state), 32'h2);
    chk("lost_delay", 32'(n), 32'd20);
    chk("lost_mode", 32'(mode), 32'(LostMode));
    chk("lost_flag", 32'(lost), 32'h1);
    chk("lost_chg", 32'(chg_cnt), 32'h2);

    apply_vec(5);

    // Reset asserted mid-HOLD with the lost counter at 3.
    set_sens(3'b000);
    wait_state(2'd1, 20, n);
    chk("hold2_state", 32'(state), 32'h1);
    step(14);
    rst = 1'b0;
    #1;
    chk("async_mode", 32'(mode), 32'h7);
    chk("async_lost", 32'(lost), 32'h0);
    chk("async_state", 32'(state), 32'h0);
    chk("async_chg", 32'(mode_chg), 32'h0);
    step(2);
    rst = 1'b1;
    chg_cnt = 0;
    step(11);
    chk("rel_pre_state", 32'(state), 32'h0);
    chk("rel_pre_mode", 32'(mode), 32'h7);
    step(1);
    chk("rel_hold_state", 32'(state), 32'h1);
    chk("rel_hold_mode", 32'(mode), 32'h0);
    step(19);
    chk("rel_prelost_state", 32'(state), 32'h1);
    step(1);
    chk("rel_lost_state", 32'(state), 32'h2);
    chk("rel_lost_mode", 32'(mode), 32'(LostMode2));
    chk("rel_lost_flag", 32'(lost), 32'h1);
    chk("rel_chg", 32'(chg_cnt), 32'h2);

    apply_vec(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_tracker_frontend.md
Name: line_tracker_frontend

Overview:
- Upstream stage of the car's motor controller.
- Samples the three IR line sensors (left, centre, right) and synchronises them into the clock domain.
- Debounces the joint 3-bit pattern at a divided tick rate.
- Runs a small lost-line FSM and emits the registered 3-bit mode word that the motor stage consumes directly, plus status strobes.

Parameters:
- SAMPLE_DIV, 100000: clk cycles per sample tick (1 kHz at 100 MHz); legal range ≥2.
- DEBOUNCE_N, 4: consecutive identical ticks required to commit a new pattern; legal range 1..15.
- LOST_TICKS, 200: ticks of committed 3'b000 before declaring the line lost; legal range ≥1.
- SENSOR_ACTIVE_HIGH, 1: 1 means a raw sensor high = line seen; 0 means inverted sensors.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-low reset.
- sensor_l, input, 1: raw left IR sensor, asynchronous.
- sensor_c, input, 1: raw centre IR sensor, asynchronous.
- sensor_r, input, 1: raw right IR sensor, asynchronous.
- mode, output, 3: {left,centre,right} command word to the motor stage.
- mode_chg, output, 1: one-cycle pulse whenever mode changes value.
- lost, output, 1: high while the FSM is in LOST.
- state, output, 2: FSM state for debug (TRACK=0, HOLD=1, LOST=2).

Behaviour:
- Reset (rst low, async): mode=3'b111, mode_chg=0, lost=0, state=TRACK, sync flops=0, tick counter=0, candidate=3'b111, stable count=0.
- Input conditioning: each sensor passes through a 2-flop synchroniser, then is XOR-inverted if SENSOR_ACTIVE_HIGH=0. The result is sync_pat[2:0] = {l,c,r}.
- Tick generation: free-running counter 0..SAMPLE_DIV-1. tick is a 1-cycle pulse when the count wraps to 0.
- Debounce, evaluated on tick only:
  - if sync_pat == candidate, stable count increments, saturating at DEBOUNCE_N-1;
  - otherwise candidate=sync_pat and stable count=0.
  - A pattern is committed when stable count reaches DEBOUNCE_N-1. This includes the tick on which it reaches that value.
  - With DEBOUNCE_N=1, every tick commits.
- FSM, updated on commit ticks plus lost timing:
  - TRACK: mode=committed pattern. Committed 000 -> HOLD, lost counter=0, mode=3'b000 (the motor stage holds its last turn).
  - HOLD: the lost counter increments each tick while the committed pattern is 000. At LOST_TICKS -> LOST, mode=3'b010 (motor reverse code), lost=1. Any nonzero commit -> TRACK, mode=pattern.
  - LOST: lost=1, mode=3'b010. Any nonzero commit -> TRACK, lost=0, mode=pattern, same cycle.
- Patterns 010 and 101 committed in TRACK pass through unchanged; the motor stage treats them as reverse.
- Latency, raw edge to mode: 2 sync cycles + up to SAMPLE_DIV*DEBOUNCE_N cycles + 1 output register cycle.
- mode_chg asserts in the cycle mode takes its new value, and only when the old and new values differ.
- Simultaneous events: the commit and the lost-counter terminal count on the same tick resolve in favour of the nonzero commit, giving TRACK.
- Mid-operation reset: all state returns to the reset values immediately. No partial debounce survives.
- Widths: the lost counter is sized $clog2(LOST_TICKS+1) and saturates. The tick counter is sized $clog2(SAMPLE_DIV).

Optional Feature:
- Macro LINE_TRACKER_LAST_TURN_EN.
- When defined:
  - a 1-bit last_turn register records the side of the most recent committed pattern containing exactly one of l or r (100/110 = left, 001/011 = right). It resets to left.
  - In LOST, mode=3'b100 (hard left) or 3'b001 (hard right) per last_turn, instead of 3'b010.
- When undefined: LOST always outputs 3'b010 and no last_turn register exists.

Decomposition:
- Shared package line_tracker_pkg holds:
  - mode constants MODE_FWD=3'b111, MODE_NONE=3'b000, MODE_REV=3'b010, MODE_HARD_L=3'b100, MODE_HARD_R=3'b001;
  - the FSM state enum (TRACK/HOLD/LOST).
- One sub-module, tracker_debounce: synchroniser, tick divider and debounce. It outputs the committed pattern plus a commit strobe. The FSM stays in the top.

Test Plan (SAMPLE_DIV=4, DEBOUNCE_N=3, LOST_TICKS=5):
- Reset released, sensors 111 held -> mode=111, state=0, mode_chg never pulses.
- Sensors 111->110 held → mode becomes 110 within 2+12+1 clk, with a single mode_chg pulse.
- Sensors glitch 111->011 for 5 clk then back to 111 -> mode stays 111, no mode_chg.
- Sensors 000 held → mode=000 (HOLD, state=1), then after 5 further ticks mode=010, lost=1, state=2. With LINE_TRACKER_LAST_TURN_EN and a prior 011 commit, expect mode=001 instead.
- From LOST, sensors 011 held 3 ticks → mode=011, lost=0, state=0, one mode_chg.
- Assert rst low mid-HOLD (lost counter=3) → mode=111, lost=0, state=0 asynchronously. After release with 000 held, LOST again requires the full 3-tick debounce plus 5 ticks.
